biometrics_controller: RTL

Top-level sequencer for the voice biometrics pipeline. Turns user requests (enroll / verify) into timed windows on the pipeline's write-enable and predict-enable controls, counts completed FFT frames, and votes per-frame classifier detections into an unlock/reject decision. Tracks consecutive failures, enforces a lockout, and aborts on a stalled frame stream. Sits between the button/debounce logic and the biometrics datapath.

---
 rtl/biometrics_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/biometrics_controller.sv
// rtl/biometrics_controller.sv - enroll/verify sequencer with frame voting, lockout and stall timeout
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   enroll_req_in             single-cycle enroll request (IDLE only)
//   verify_req_in             single-cycle verify request (IDLE only, wins over enroll)
//   abort_in                  user abort (ENROLL/VERIFY/RESULT)
//   frame_done_in             one pulse per completed FFT frame
//   detected_in               per-frame classifier match, sampled with frame_done_in
//   write_enable_out          enrollment (Bluetooth write) window
//   predict_enable_out        verification (classify) window
//   busy_out                  any state other than IDLE
//   unlock_out                held for RESULT_CYCLES after a passing vote
//   reject_pulse_out          one cycle per failing vote
//   error_pulse_out           one cycle per frame-stream timeout
//   locked_out                lockout window
//   fail_count_out            consecutive failing votes
module biometrics_controller #(
    parameter int ENROLL_FRAMES   = 64,
    parameter int VERIFY_FRAMES   = 16,
    parameter int MATCH_THRESHOLD = 10,
    parameter int MAX_FAILS       = 3,
    parameter int RESULT_CYCLES   = 1000,
    parameter int LOCKOUT_CYCLES  = 100000,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           enroll_req_in,
    input  logic                           verify_req_in,
    input  logic                           abort_in,
    input  logic                           frame_done_in,
    input  logic                           detected_in,
    output logic                           write_enable_out,
    output logic                           predict_enable_out,
    output logic                           busy_out,
    output logic                           unlock_out,
    output logic                           reject_pulse_out,
    output logic                           error_pulse_out,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENROLL  = 3'd1;
    localparam logic [2:0] S_VERIFY  = 3'd2;
    localparam logic [2:0] S_DECIDE  = 3'd3;
    localparam logic [2:0] S_RESULT  = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    localparam int FRAME_MAX = (ENROLL_FRAMES > VERIFY_FRAMES) ? ENROLL_FRAMES : VERIFY_FRAMES;
    localparam int HOLD_MAX  = (RESULT_CYCLES > LOCKOUT_CYCLES) ? RESULT_CYCLES : LOCKOUT_CYCLES;
    localparam int FW = $clog2(FRAME_MAX + 1);
    localparam int MW = $clog2(VERIFY_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int CW = $clog2(MAX_FAILS + 1);

    // Terminal values are compared against the current count, so the exit
    // happens on the edge where the count would reach its maximum.
    localparam logic [FW-1:0] ENROLL_LAST = FW'(ENROLL_FRAMES - 1);
    localparam logic [FW-1:0] VERIFY_LAST = FW'(VERIFY_FRAMES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] RESULT_LAST = HW'(RESULT_CYCLES - 1);
    localparam logic [HW-1:0] LOCK_LAST   = HW'(LOCKOUT_CYCLES - 1);
    localparam logic [CW-1:0] FAIL_LAST   = CW'(MAX_FAILS - 1);
    localparam logic [MW-1:0] MATCH_MIN   = MW'(MATCH_THRESHOLD);

    logic [2:0]    state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [MW-1:0] match_q, match_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] fail_q, fail_d;
    logic          reject_d, error_d;
    logic          we_q, pe_q, busy_q, unlock_q, reject_q, error_q, locked_q;
    logic [FW-1:0] frame_last;

    assign frame_last = (state_q == S_ENROLL) ? ENROLL_LAST : VERIFY_LAST;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        match_d  = match_q;
        tmo_d    = tmo_q;
        hold_d   = hold_q;
        fail_d   = fail_q;
        reject_d = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (verify_req_in || enroll_req_in) begin
                    state_d = verify_req_in ? S_VERIFY : S_ENROLL;
                    frame_d = '0;
                    match_d = '0;
                    tmo_d   = '0;
                end
            end
            S_ENROLL, S_VERIFY: begin
                // Priority: abort, then a frame (beats a coincident timeout).
                if (abort_in) begin
                    state_d = S_IDLE;
                end else if (frame_done_in) begin
                    frame_d = frame_q + FW'(1);
                    tmo_d   = '0;
                    if (state_q == S_VERIFY) begin
                        match_d = match_q + MW'(detected_in);
                    end
                    if (frame_q == frame_last) begin
                        state_d = (state_q == S_VERIFY) ? S_DECIDE : S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DECIDE: begin
                hold_d = '0;
                if (match_q >= MATCH_MIN) begin
                    state_d = S_RESULT;
                    fail_d  = '0;
                end else begin
                    reject_d = 1'b1;
                    fail_d   = fail_q + CW'(1);
                    state_d  = (fail_q == FAIL_LAST) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_RESULT: begin
                if (abort_in || hold_q == RESULT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_LOCKOUT: begin
                if (hold_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Level outputs are decoded from the next state so they change on the
    // same edge as the state while still coming straight out of flops.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            match_q  <= '0;
            tmo_q    <= '0;
            hold_q   <= '0;
            fail_q   <= '0;
            we_q     <= 1'b0;
            pe_q     <= 1'b0;
            busy_q   <= 1'b0;
            unlock_q <= 1'b0;
            reject_q <= 1'b0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            match_q  <= match_d;
            tmo_q    <= tmo_d;
            hold_q   <= hold_d;
            fail_q   <= fail_d;
            we_q     <= (state_d == S_ENROLL);
            pe_q     <= (state_d == S_VERIFY);
            busy_q   <= (state_d != S_IDLE);
            unlock_q <= (state_d == S_RESULT);
            reject_q <= reject_d;
            error_q  <= error_d;
            locked_q <= (state_d == S_LOCKOUT);
        end
    end

    assign write_enable_out   = we_q;
    assign predict_enable_out = pe_q;
    assign busy_out           = busy_q;
    assign unlock_out         = unlock_q;
    assign reject_pulse_out   = reject_q;
    assign error_pulse_out    = error_q;
    assign locked_out         = locked_q;
    assign fail_count_out     = fail_q;

endmodule
